// File: rtl/config_stream_loader.sv
// Configuration stream loader: accepts words from a source and issues
// sequential {stage,row} write strobes toward the configuration controller.
module config_stream_loader #(
  parameter int LUTSIZE = 6,
  parameter int STAGES  = 8,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             wren_out,
  output logic [31:0]      addr_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [15:0]      progress,
  output logic             done
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [LUTSIZE-1:0] row;
  logic [SW-1:0]      stage;
  logic               hs;
  logic               last;
  logic               launch;

  assign hs     = in_valid && in_ready;
  assign last   = (stage == SW'(STAGES - 1)) && (row == '1);
  assign launch = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last) state_n = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Address and data are captured together so a strobe always has its word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wren_out <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      progress <= '0;
      row      <= '0;
      stage    <= '0;
    end else begin
      wren_out <= hs;
      if (launch) begin
        row      <= '0;
        stage    <= '0;
        progress <= '0;
      end else if (hs) begin
        addr_out <= 32'({stage, row});
        data_out <= in_data;
        row      <= row + LUTSIZE'(1);
        progress <= progress + 16'd1;
        if (row == '1) stage <= stage + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// Randomized bench for config_stream_loader against a word-index model
// of the load sequence (LUTSIZE=2, STAGES=3, WIDTH=8).
module tb_config_stream_loader;

  localparam int LUTSIZE = 2;
  localparam int STAGES  = 3;
  localparam int WIDTH   = 8;
  localparam int TOTAL   = STAGES * (1 << LUTSIZE);

  logic             clk;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             wren_out;
  logic [31:0]      addr_out;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic [15:0]      progress;
  logic             done;

  config_stream_loader #(
    .LUTSIZE(LUTSIZE),
    .STAGES (STAGES),
    .WIDTH  (WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wren_out(wren_out),
    .addr_out(addr_out),
    .data_out(data_out),
    .busy    (busy),
    .progress(progress),
    .done    (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: phase 0=idle 1=load 2=flush 3=done; words numbered 0..TOTAL-1
  int               m_phase = 0;
  int               m_acc   = 0;
  int               m_prog  = 0;
  bit               m_wren  = 0;
  logic [31:0]      m_addr  = '0;
  logic [WIDTH-1:0] m_data  = '0;
  int               slog[$];

  task automatic tick(input bit st, input bit v, input bit rs);
    logic [WIDTH-1:0] d;
    d = WIDTH'($urandom);
    start    = st;
    in_valid = v;
    in_data  = d;
    reset    = rs;
    if (rs) begin
      m_phase = 0; m_acc = 0; m_prog = 0;
      m_wren = 0; m_addr = '0; m_data = '0;
    end else begin
      m_wren = 0;
      case (m_phase)
        0, 3: if (st) begin m_phase = 1; m_acc = 0; m_prog = 0; end
        1: if (v) begin
          m_wren = 1;
          m_addr = 32'(m_acc);
          m_data = d;
          m_acc++;
          m_prog = m_acc;
          if (m_acc == TOTAL) m_phase = 2;
        end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    start    = 0;
    in_valid = 0;
    reset    = 0;
    if (wren_out === 1'b1) slog.push_back(int'(addr_out));
  endtask

  task automatic test_reset();
    tick(1, 1, 1);
    checks++; if (wren_out !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", wren_out); end
    checks++; if (addr_out !== 32'd0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", addr_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data got=%0h exp=0", data_out); end
    checks++; if (progress !== 16'd0) begin errors++; $display("FAIL rst_prog got=%0d exp=0", progress); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tick(0, 1, 0);
    checks++; if (in_ready !== 1'b0 || wren_out !== 1'b0) begin
      errors++; $display("FAIL idle_quiet ready=%b wren=%b exp=0/0", in_ready, wren_out);
    end
  endtask

  task automatic test_full_stream();
    int hs_cyc = -1;
    int done_cyc = -1;
    slog.delete();
    tick(1, 0, 0);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL full_enter ready=%b busy=%b exp=1/1", in_ready, busy);
    end
    for (int t = 0; t < 40 && m_phase != 3; t++) begin
      tick(0, 1, 0);
      if (m_acc == TOTAL && hs_cyc < 0) hs_cyc = t;
      if (done === 1'b1 && done_cyc < 0) done_cyc = t + 1;
      checks++; if (wren_out !== m_wren) begin errors++; $display("FAIL full_wren t=%0d got=%b exp=%b", t, wren_out, m_wren); end
      checks++; if (addr_out !== m_addr) begin errors++; $display("FAIL full_addr t=%0d got=%0d exp=%0d", t, addr_out, m_addr); end
      checks++; if (data_out !== m_data) begin errors++; $display("FAIL full_data t=%0d got=%0h exp=%0h", t, data_out, m_data); end
      checks++; if (progress !== 16'(m_prog)) begin errors++; $display("FAIL full_prog t=%0d got=%0d exp=%0d", t, progress, m_prog); end
      checks++; if (done !== (m_phase == 3)) begin errors++; $display("FAIL full_done t=%0d got=%b exp=%b", t, done, m_phase == 3); end
      checks++; if (in_ready !== (m_phase == 1)) begin errors++; $display("FAIL full_ready t=%0d got=%b exp=%b", t, in_ready, m_phase == 1); end
      checks++; if (busy !== (m_phase == 1 || m_phase == 2)) begin errors++; $display("FAIL full_busy t=%0d got=%b", t, busy); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_timeout done=%b exp=1", done); end
    checks++; if (done_cyc - hs_cyc != 2) begin errors++; $display("FAIL full_done_lat got=%0d exp=2", done_cyc - hs_cyc); end
    checks++; if (slog.size() != TOTAL) begin errors++; $display("FAIL full_count got=%0d exp=%0d", slog.size(), TOTAL); end
  endtask

  task automatic test_toggle();
    tick(0, 0, 1);
    tick(1, 0, 0);
    slog.delete();
    for (int t = 0; t < 60 && m_phase != 3; t++) begin
      tick(0, (t % 2) == 0, 0);
      checks++; if (wren_out !== m_wren) begin errors++; $display("FAIL tog_wren t=%0d got=%b exp=%b", t, wren_out, m_wren); end
      checks++; if (addr_out !== m_addr) begin errors++; $display("FAIL tog_addr t=%0d got=%0d exp=%0d", t, addr_out, m_addr); end
      checks++; if (data_out !== m_data) begin errors++; $display("FAIL tog_data t=%0d got=%0h exp=%0h", t, data_out, m_data); end
      checks++; if (progress !== 16'(m_prog)) begin errors++; $display("FAIL tog_prog t=%0d got=%0d exp=%0d", t, progress, m_prog); end
    end
    checks++; if (slog.size() != TOTAL) begin errors++; $display("FAIL tog_count got=%0d exp=%0d", slog.size(), TOTAL); end
    foreach (slog[k]) begin
      checks++; if (slog[k] != k) begin errors++; $display("FAIL tog_seq k=%0d got=%0d exp=%0d", k, slog[k], k); end
    end
  endtask

  task automatic test_row_wrap();
    tick(0, 0, 1);
    tick(1, 0, 0);
    slog.delete();
    for (int t = 0; t < 80 && m_phase != 3; t++) begin
      tick(0, ($urandom % 4) != 0, 0);
      checks++; if (addr_out !== m_addr || wren_out !== m_wren) begin
        errors++; $display("FAIL wrap_strobe t=%0d got=%0d/%b exp=%0d/%b", t, addr_out, wren_out, m_addr, m_wren);
      end
    end
    if (slog.size() != TOTAL) begin
      checks++; errors++; $display("FAIL wrap_count got=%0d exp=%0d", slog.size(), TOTAL);
    end else begin
      checks++; if (slog[3] != 3) begin errors++; $display("FAIL wrap_w4 got=%0d exp=3", slog[3]); end
      checks++; if (slog[4] != 4) begin errors++; $display("FAIL wrap_w5 got=%0d exp=4", slog[4]); end
      checks++; if (slog[8] != 8) begin errors++; $display("FAIL wrap_w9 got=%0d exp=8", slog[8]); end
      checks++; if (slog[11] != 11) begin errors++; $display("FAIL wrap_w12 got=%0d exp=11", slog[11]); end
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, 1);
    tick(1, 0, 0);
    for (int t = 0; t < 20 && m_acc < 5; t++) tick(0, 1, 0);
    checks++; if (progress !== 16'd5) begin errors++; $display("FAIL mid_prog5 got=%0d exp=5", progress); end
    tick(0, 1, 1);
    checks++; if (wren_out !== 1'b0) begin errors++; $display("FAIL mid_wren got=%b exp=0", wren_out); end
    checks++; if (progress !== 16'd0) begin errors++; $display("FAIL mid_prog got=%0d exp=0", progress); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_idle ready=%b busy=%b exp=0/0", in_ready, busy);
    end
    tick(0, 1, 0);
    checks++; if (wren_out !== 1'b0) begin errors++; $display("FAIL mid_nostrobe got=%b exp=0", wren_out); end
    tick(1, 0, 0);
    tick(0, 1, 0);
    checks++; if (wren_out !== 1'b1 || addr_out !== 32'd0) begin
      errors++; $display("FAIL mid_restart wren=%b addr=%0d exp=1/0", wren_out, addr_out);
    end
    checks++; if (data_out !== m_data) begin errors++; $display("FAIL mid_data got=%0h exp=%0h", data_out, m_data); end
  endtask

  task automatic test_start_during_load();
    tick(0, 0, 1);
    tick(1, 0, 0);
    slog.delete();
    for (int t = 0; t < 40 && m_phase != 3; t++) begin
      tick(m_acc == 2 || m_phase == 2, 1, 0);
      checks++; if (progress !== 16'(m_prog)) begin errors++; $display("FAIL sdl_prog t=%0d got=%0d exp=%0d", t, progress, m_prog); end
    end
    checks++; if (progress !== 16'(TOTAL) || done !== 1'b1) begin
      errors++; $display("FAIL sdl_end prog=%0d done=%b exp=%0d/1", progress, done, TOTAL);
    end
    checks++; if (slog.size() != TOTAL) begin errors++; $display("FAIL sdl_count got=%0d exp=%0d", slog.size(), TOTAL); end
    for (int t = 0; t < 3; t++) begin
      tick(0, 1, 0);
      checks++; if (wren_out !== 1'b0 || in_ready !== 1'b0 || progress !== 16'(TOTAL) || done !== 1'b1) begin
        errors++; $display("FAIL done_hold wren=%b ready=%b prog=%0d done=%b", wren_out, in_ready, progress, done);
      end
    end
  endtask

  task automatic test_restart_from_done();
    tick(1, 0, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rs_done got=%b exp=0", done); end
    checks++; if (progress !== 16'd0) begin errors++; $display("FAIL rs_prog got=%0d exp=0", progress); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got=%b exp=1", in_ready); end
    slog.delete();
    for (int t = 0; t < 80 && m_phase != 3; t++) begin
      tick(0, ($urandom % 3) != 0, 0);
      checks++; if (data_out !== m_data || addr_out !== m_addr) begin
        errors++; $display("FAIL rs_word t=%0d got=%0d:%0h exp=%0d:%0h", t, addr_out, data_out, m_addr, m_data);
      end
    end
    checks++; if (done !== 1'b1 || progress !== 16'(TOTAL)) begin
      errors++; $display("FAIL rs_end done=%b prog=%0d exp=1/%0d", done, progress, TOTAL);
    end
    foreach (slog[k]) begin
      checks++; if (slog[k] != k) begin errors++; $display("FAIL rs_seq k=%0d got=%0d exp=%0d", k, slog[k], k); end
    end
  endtask

  initial begin
    clk      = 0;
    reset    = 1;
    start    = 0;
    in_valid = 0;
    in_data  = '0;
    test_reset();
    test_full_stream();
    test_toggle();
    test_row_wrap();
    test_reset_mid();
    test_start_during_load();
    test_restart_from_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
